// File: rtl/vai_tx_rr_sched_pkg.sv
// Shared types and the rotating-priority pick helper for the Tx round-robin scheduler.
package vai_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } t_sched_state;

  localparam int MAX_REQ  = 32;
  localparam int PICK_W   = 5;
  localparam int CREDIT_W = 4;
  localparam int STAT_W   = 32;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } t_pick;

  // First set bit of eligible at or after ptr, wrapping at num; found=0 when none is set.
  function automatic t_pick rr_pick(input logic [MAX_REQ-1:0] eligible,
                                    input logic [PICK_W-1:0]  ptr,
                                    input int                 num);
    t_pick res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= num) j = j - num;
      if (k < num && !res.found && eligible[PICK_W'(j)]) begin
        res.found = 1'b1;
        res.idx   = PICK_W'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vai_tx_rr_sched_if.sv
// Request-side and upstream Tx-side signals of the round-robin scheduler.
// Handshake: a requester beat is consumed on a cycle where req_valid[i] & req_ready[i];
// req_ready is one-hot or zero, and tx_valid/tx_data/tx_src present that beat one cycle later.
interface vai_tx_rr_sched_if #(
  parameter int NUM_REQ    = 8,
  parameter int DATA_WIDTH = 612
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_mask;
  logic                          tx_almfull;
  logic                          tx_valid;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic [IDX_W-1:0]              tx_src;

  modport slave (
    input  req_valid, req_last, req_data, req_mask, tx_almfull,
    output req_ready, tx_valid, tx_data, tx_src
  );

  modport master (
    output req_valid, req_last, req_data, req_mask, tx_almfull,
    input  req_ready, tx_valid, tx_data, tx_src
  );
endinterface

// File: rtl/vai_tx_rr_sched_arbiter.sv
// Combinational rotating-priority pick: first eligible requester at or after ptr.
module vai_rr_arbiter
  import vai_sched_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  t_pick pick;
  logic  unused_pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(eligible), PICK_W'(ptr), NUM_REQ);
    found = pick.found;
    idx   = pick.idx[IDX_W-1:0];
  end

  assign unused_pick = ^pick;
endmodule

// File: rtl/vai_tx_rr_sched.sv
// Round-robin share of one CCI-P Tx channel with packet locking and almost-full slack credit.
// Define VAI_TX_SCHED_STATS_EN to add per-requester packet counters on stat_grants.
module vai_tx_rr_sched
  import vai_sched_pkg::*;
#(
  parameter int  NUM_REQ       = 8,
  parameter int  DATA_WIDTH    = 612,
  parameter int  ALMFULL_SLACK = 4,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  vai_tx_rr_sched_if.slave       bus,
  output logic                   slack_err,
`ifdef VAI_TX_SCHED_STATS_EN
  output logic [NUM_REQ*32-1:0]  stat_grants,
`endif
  output t_sched_state           dbg_state,
  output logic [IDX_W-1:0]       dbg_rr_ptr
);
  t_sched_state        state, state_n;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_n, owner, owner_n, win, pick_idx;
  logic [CREDIT_W-1:0] credit;
  logic [NUM_REQ-1:0]  eligible, grant;
  logic                found, issue, can_issue;

  assign eligible  = bus.req_valid & ~bus.req_mask;
  assign can_issue = !bus.tx_almfull || (credit != '0);

  vai_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .found    (found),
    .idx      (pick_idx)
  );

  // A locked owner that goes masked simply stops being eligible, which stalls the channel.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    grant    = '0;
    issue    = 1'b0;
    win      = owner;
    if (!reset && can_issue) begin
      case (state)
        IDLE: begin
          if (found) begin
            issue           = 1'b1;
            win             = pick_idx;
            grant[pick_idx] = 1'b1;
            rr_ptr_n        = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (!bus.req_last[pick_idx]) begin
              state_n = LOCKED;
              owner_n = pick_idx;
            end
          end
        end
        LOCKED: begin
          if (eligible[owner]) begin
            issue        = 1'b1;
            grant[owner] = 1'b1;
            if (bus.req_last[owner]) state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      credit       <= CREDIT_W'(ALMFULL_SLACK);
      slack_err    <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_src   <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      owner  <= owner_n;
      // A beat issued in the same cycle almfull rises already counts against the slack.
      if (!bus.tx_almfull)             credit <= CREDIT_W'(ALMFULL_SLACK);
      else if (issue && credit != '0)  credit <= credit - 1'b1;
      if (issue && bus.tx_almfull && credit == '0) slack_err <= 1'b1;
      bus.tx_valid <= issue;
      if (issue) begin
        bus.tx_data <= bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
        bus.tx_src  <= win;
      end
    end
  end

`ifdef VAI_TX_SCHED_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (issue && bus.req_last[win]) begin
      grant_cnt[win] <= grant_cnt[win] + 1'b1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = grant_cnt[i];
  end
`endif
endmodule

// File: tb/tb_vai_tx_rr_sched.sv
// Self-checking bench for vai_tx_rr_sched: vector table, hand sequences and a randomized run.
module tb_vai_tx_rr_sched;
  import vai_sched_pkg::*;

  localparam int N     = 8;
  localparam int DW    = 612;
  localparam int SLACK = 4;
  localparam int IW    = 3;
  localparam int QW    = IW + DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vai_tx_rr_sched_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  logic         slack_err;
  t_sched_state dbg_state;
  logic [IW-1:0] dbg_rr_ptr;
`ifdef VAI_TX_SCHED_STATS_EN
  logic [N*32-1:0] stat_grants;
`endif

  vai_tx_rr_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ALMFULL_SLACK(SLACK)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .slack_err  (slack_err),
`ifdef VAI_TX_SCHED_STATS_EN
    .stat_grants(stat_grants),
`endif
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [QW-1:0] exp_q[$];
  logic [N-1:0]  got_ready;

  // Reference model: owner=-1 means no packet in progress.
  int m_ptr = 0, m_owner = -1, m_credit = SLACK;
  int m_cnt[N];

  typedef struct {
    logic       rst;
    logic [7:0] valid;
    logic [7:0] last;
    logic [7:0] mask;
    logic       af;
    logic [7:0] exp_ready;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] v, l, m, input logic af,
                            output int gi);
    bit can;
    gi = -1;
    if (r) begin
      m_ptr = 0; m_owner = -1; m_credit = SLACK;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      return;
    end
    can = !af || (m_credit > 0);
    if (can) begin
      if (m_owner >= 0) begin
        if (v[m_owner] && !m[m_owner]) gi = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (gi < 0 && v[(m_ptr + k) % N] && !m[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      end
    end
    if (gi >= 0) begin
      if (m_owner < 0) m_ptr = (gi + 1) % N;
      m_owner = l[gi] ? -1 : gi;
      if (l[gi]) m_cnt[gi]++;
    end
    if (!af) m_credit = SLACK;
    else if (gi >= 0) m_credit--;
  endtask

  // Drive one cycle from a negedge; ends at the following negedge.
  task automatic cycle(input logic r, input logic [N-1:0] v, l, m, input logic af);
    int gi;
    logic [N-1:0] eg;
    reset          = r;
    bus.req_valid  = v;
    bus.req_last   = l;
    bus.req_mask   = m;
    bus.tx_almfull = af;
    for (int i = 0; i < (N*DW)/32; i++) bus.req_data[i*32 +: 32] = $urandom();
    #1;
    model_step(r, v, l, m, af, gi);
    eg = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      exp_q.push_back({IW'(gi), bus.req_data[gi*DW +: DW]});
    end
    got_ready = bus.req_ready;
    check("req_ready", got_ready, eg);
    @(posedge clk); #1;
    check("tx_valid", bus.tx_valid, gi >= 0);
    if (bus.tx_valid) begin
      if (exp_q.size() == 0) check("tx_beat_unexpected", 1, 0);
      else check("tx_src_data", {bus.tx_src, bus.tx_data}, exp_q.pop_front());
    end
    exp_q.delete();
    check("rr_ptr", dbg_rr_ptr, m_ptr);
    check("state", dbg_state, (m_owner >= 0) ? LOCKED : IDLE);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [7:0] v, l, m, input logic af, input logic [7:0] e);
    vec_t t;
    t = '{r, v, l, m, af, e};
    tbl.push_back(t);
  endtask

  initial begin
    logic [7:0] t4[8];
    logic [7:0] t3[6];
    logic [N-1:0] rv, rl, rm;
    logic raf, rr;
    int left[N];

    reset = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.req_mask = '0;
    bus.req_data = '0; bus.tx_almfull = 1'b0;
    @(negedge clk);

    // Rotation over all requesters, then wrap.
    add(1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    for (int k = 0; k < 9; k++) add(0, 8'hFF, 8'hFF, 8'h00, 0, 8'(1 << (k % 8)));
    // Requester 3 masked.
    t4 = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    add(1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    foreach (t4[k]) add(0, 8'hFF, 8'hFF, 8'h08, 0, t4[k]);
    // Almost-full held: exactly SLACK beats, then resume from rr_ptr=1.
    t3 = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h00, 8'h00};
    add(1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    foreach (t3[k]) add(0, 8'h07, 8'hFF, 8'h00, 1, t3[k]);
    add(0, 8'h07, 8'hFF, 8'h00, 0, 8'h02);
    // 4-beat packet from 2 while 5 waits.
    add(1, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    for (int k = 0; k < 3; k++) add(0, 8'h24, 8'h20, 8'h00, 0, 8'h04);
    add(0, 8'h24, 8'h24, 8'h00, 0, 8'h04);
    add(0, 8'h20, 8'h20, 8'h00, 0, 8'h20);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].mask, tbl[i].af);
      if (!tbl[i].rst) check("tbl_ready", got_ready, tbl[i].exp_ready);
    end
    check("slack_err_tbl", slack_err, 0);

    // Reset in the middle of a 4-beat packet drops the lock.
    cycle(1, 8'h00, 8'h00, 8'h00, 0);
    cycle(0, 8'h44, 8'h40, 8'h00, 0);
    cycle(0, 8'h44, 8'h40, 8'h00, 0);
    check("t5_beat2_ready", got_ready, 8'h04);
    cycle(1, 8'h44, 8'h40, 8'h00, 0);
    check("t5_tx_valid", bus.tx_valid, 0);
    check("t5_state", dbg_state, IDLE);
    check("t5_rr_ptr", dbg_rr_ptr, 0);
    cycle(0, 8'h40, 8'h40, 8'h00, 0);
    check("t5_after_ready", got_ready, 8'h40);

    // Locked owner masked or idle stalls everyone else.
    cycle(1, 8'h00, 8'h00, 8'h00, 0);
    cycle(0, 8'h03, 8'h02, 8'h00, 0);
    check("lock_grant", got_ready, 8'h01);
    cycle(0, 8'h03, 8'h02, 8'h01, 0);
    check("lock_masked", got_ready, 8'h00);
    cycle(0, 8'h02, 8'h02, 8'h00, 0);
    check("lock_owner_idle", got_ready, 8'h00);
    cycle(0, 8'h03, 8'h03, 8'h00, 0);
    check("lock_release", got_ready, 8'h01);
    cycle(0, 8'h03, 8'h03, 8'h00, 0);
    check("after_release", got_ready, 8'h02);

`ifdef VAI_TX_SCHED_STATS_EN
    cycle(1, 8'h00, 8'h00, 8'h00, 0);
    for (int k = 0; k < 10; k++) cycle(0, 8'h02, 8'h02, 8'h00, 0);
    for (int i = 0; i < N; i++) check("stat_req1", stat_grants[i*32 +: 32], (i == 1) ? 10 : 0);
`endif

    // Randomized traffic against the model.
    cycle(1, 8'h00, 8'h00, 8'h00, 0);
    foreach (left[i]) left[i] = 0;
    rm = '0; raf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 && $urandom_range(0, 2) == 0) left[i] = $urandom_range(1, 4);
        rv[i] = (left[i] > 0) && ($urandom_range(0, 5) != 0);
        rl[i] = (left[i] == 1);
      end
      if ($urandom_range(0, 15) == 0) rm[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) raf = ~raf;
      cycle(rr, rv, rl, rm, raf);
      for (int i = 0; i < N; i++) begin
        if (rr) left[i] = 0;
        else if (got_ready[i] && rv[i]) left[i]--;
      end
    end
    check("slack_err_final", slack_err, 0);
`ifdef VAI_TX_SCHED_STATS_EN
    for (int i = 0; i < N; i++) check("stat_random", stat_grants[i*32 +: 32], m_cnt[i]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
